// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: MIPS instruction fetch stage. Owns the PC, issues one
// outstanding word read to instruction memory and queues returned words for decode.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   imem_req_valid/ready/addr     fetch request channel (word aligned address)
//   imem_rsp_valid/data           in-order read response, one per accepted request
//   redirect_valid/pc             branch/jump redirect from execute (flushes everything)
//   out_valid/ready               instruction handshake toward decode
//   out_instr/pc/pc_plus4         queue head: instruction, its address, address + 4
//
// Optional: define FETCH_PERF_EN to add stall_cycles[31:0] and flush_count[15:0],
// saturating counters of empty-output cycles and redirects.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_L = CW'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   tag_pc;
    logic          discard;

    logic [31:0]   instr_q [QDEPTH];
    logic [31:0]   pc_q    [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic          push;
    logic          pop;
    logic [31:0]   target;
    logic [1:0]    unused_redirect_low;

    assign target              = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_low = redirect_pc[1:0];

    // A response in the redirect cycle or tagged for discard never enters the queue.
    assign push = (state == WAIT) && imem_rsp_valid && !discard && !redirect_valid;
    assign pop  = out_valid && out_ready && !redirect_valid;

    assign count_next = count + CW'(push) - CW'(pop);

    assign out_valid    = (count != '0);
    assign out_instr    = out_valid ? instr_q[head] : '0;
    assign out_pc       = out_valid ? pc_q[head] : '0;
    assign out_pc_plus4 = out_valid ? pc_q[head] + 32'd4 : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[tail] <= imem_rsp_data;
            pc_q[tail]    <= tag_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            fetch_pc       <= RESET_PC;
            tag_pc         <= RESET_PC;
            discard        <= 1'b0;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
        end else begin
            if (push) begin
                assert (count != DEPTH_L);
            end
            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                count <= count_next;
            end

            unique case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= target;
                        fetch_pc       <= target;
                    end else if (count < DEPTH_L) begin
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= fetch_pc;
                    end
                end
                REQ: begin
                    if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        tag_pc         <= fetch_pc;
                        state          <= WAIT;
                        // Accepted request belongs to the old stream: drop its reply.
                        if (redirect_valid) begin
                            discard  <= 1'b1;
                            fetch_pc <= target;
                        end else begin
                            fetch_pc <= fetch_pc + 32'd4;
                        end
                    end else if (redirect_valid) begin
                        imem_req_addr <= target;
                        fetch_pc      <= target;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        discard <= 1'b0;
                        // Nothing is outstanding any more, so credits depend only on occupancy.
                        if (redirect_valid) begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                            imem_req_addr  <= target;
                            fetch_pc       <= target;
                        end else if (count_next < DEPTH_L) begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                            imem_req_addr  <= fetch_pc;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (redirect_valid) begin
                        discard  <= 1'b1;
                        fetch_pc <= target;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!out_valid && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect_valid && flush_count != '1) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule
